// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/debug memory-port arbiter.
// Pure declarations: no latency or flow-control behaviour of its own.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   typedef enum logic {
      CPU = 1'b0,
      DBG = 1'b1
   } owner_t;

   // Wait-counter width; a zero wait-state build still needs one bit.
   function automatic int cnt_width(input int ws);
      return (ws < 1) ? 1 : $clog2(ws + 1);
   endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter for memory wait states; o_last marks the final wait cycle.
// Count is visible the cycle after load and saturates at zero; no backpressure.
module wait_counter
   import mem_arb_pkg::*;
#(
   parameter int WAIT_STATES = 2,
   localparam int CW = cnt_width(WAIT_STATES)
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_dec,
   output logic o_last
);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= CW'(WAIT_STATES);
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_last = (r_count == CW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and the debug/loader port.
// Ready 2+WAIT_STATES cycles after the request is sampled in IDLE; losers hold req until served.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WAIT_STATES = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              dbg_req,
   input  logic              cpu_we,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              cpu_ready,
   output logic              dbg_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner,
   output logic [1:0]        dbg_arbstate
);

   arb_state_t        r_state;
   owner_t            r_owner;
   owner_t            r_last_owner;
   owner_t            w_pick;
   logic              r_we;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dbg_rdata;
   logic              r_cpu_ready;
   logic              r_dbg_ready;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_cnt_last;
   logic              w_to_done;

   wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait_counter (
      .clk    (clk),
      .reset  (reset),
      .i_load (r_state == ACCESS),
      .i_dec  (r_state == WAIT),
      .o_last (w_cnt_last)
   );

   // On a tie the requester not served last wins.
   always_comb begin
      w_pick = CPU;
      if (cpu_req && dbg_req) begin
         w_pick = (r_last_owner == CPU) ? DBG : CPU;
      end else if (dbg_req) begin
         w_pick = DBG;
      end
   end

   assign w_sel_we    = (w_pick == DBG) ? dbg_we    : cpu_we;
   assign w_sel_addr  = (w_pick == DBG) ? dbg_addr  : cpu_addr;
   assign w_sel_wdata = (w_pick == DBG) ? dbg_wdata : cpu_wdata;

   assign w_to_done = ((r_state == ACCESS) && (WAIT_STATES == 0)) ||
                      ((r_state == WAIT) && w_cnt_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_owner      <= CPU;
         r_last_owner <= DBG;
         r_we         <= 1'b0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
         r_cpu_ready  <= 1'b0;
         r_dbg_ready  <= 1'b0;
      end else begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_cpu_ready <= 1'b0;
         r_dbg_ready <= 1'b0;
         if (w_to_done) begin
            if (!r_we) begin
               if (r_owner == CPU) r_cpu_rdata <= mem_rdata;
               else                r_dbg_rdata <= mem_rdata;
            end
            r_cpu_ready <= (r_owner == CPU);
            r_dbg_ready <= (r_owner == DBG);
         end
         case (r_state)
            IDLE: begin
               if (cpu_req || dbg_req) begin
                  r_owner  <= w_pick;
                  r_we     <= w_sel_we;
                  r_addr   <= w_sel_addr;
                  r_wdata  <= w_sel_wdata;
                  r_mem_en <= 1'b1;
                  r_mem_we <= w_sel_we;
                  r_state  <= ACCESS;
               end
            end
            ACCESS:  r_state <= w_to_done ? DONE : WAIT;
            WAIT:    if (w_to_done) r_state <= DONE;
            DONE: begin
               r_last_owner <= r_owner;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cpu_rdata    = r_cpu_rdata;
   assign dbg_rdata    = r_dbg_rdata;
   assign cpu_ready    = r_cpu_ready;
   assign dbg_ready    = r_dbg_ready;
   assign mem_en       = r_mem_en;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_addr;
   assign mem_wdata    = r_wdata;
   assign owner        = r_owner;
   assign dbg_arbstate = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-requester scoreboards fed at issue time, checked by a negedge monitor.
// A second zero-wait-state instance covers the combinational-read memory case.
module tb_mem_arbiter;

   localparam int WS    = 2;
   localparam int BOUND = 5 + 2 * WS;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } iss_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, dbg_req, cpu_we, dbg_we;
   logic [31:0] cpu_addr, dbg_addr, cpu_wdata, dbg_wdata;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic        cpu_ready, dbg_ready, mem_en, mem_we, owner;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic [1:0]  dbg_arbstate;

   logic        z_cpu_req, z_dbg_req, z_cpu_we, z_dbg_we;
   logic [31:0] z_cpu_addr, z_dbg_addr, z_cpu_wdata, z_dbg_wdata;
   logic [31:0] z_cpu_rdata, z_dbg_rdata;
   logic        z_cpu_ready, z_dbg_ready, z_mem_en, z_mem_we, z_owner;
   logic [31:0] z_mem_addr, z_mem_wdata;
   logic [31:0] z_mem_rdata = 32'h0;
   logic [1:0]  z_dbg_arbstate;

   always #5 clk = ~clk;

   mem_arbiter #(.WAIT_STATES(WS), .ADDR_W(32), .DATA_W(32)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .dbg_req(dbg_req), .cpu_we(cpu_we), .dbg_we(dbg_we),
      .cpu_addr(cpu_addr), .dbg_addr(dbg_addr), .cpu_wdata(cpu_wdata), .dbg_wdata(dbg_wdata),
      .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata), .cpu_ready(cpu_ready), .dbg_ready(dbg_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner(owner), .dbg_arbstate(dbg_arbstate)
   );

   mem_arbiter #(.WAIT_STATES(0), .ADDR_W(32), .DATA_W(32)) u_dut0 (
      .clk(clk), .reset(reset),
      .cpu_req(z_cpu_req), .dbg_req(z_dbg_req), .cpu_we(z_cpu_we), .dbg_we(z_dbg_we),
      .cpu_addr(z_cpu_addr), .dbg_addr(z_dbg_addr), .cpu_wdata(z_cpu_wdata), .dbg_wdata(z_dbg_wdata),
      .cpu_rdata(z_cpu_rdata), .dbg_rdata(z_dbg_rdata), .cpu_ready(z_cpu_ready), .dbg_ready(z_dbg_ready),
      .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
      .mem_rdata(z_mem_rdata), .owner(z_owner), .dbg_arbstate(z_dbg_arbstate)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   iss_t        iss_q0[$], iss_q1[$];
   logic [31:0] cmp_q0[$], cmp_q1[$];
   logic        own_q[$];
   logic [31:0] held [2];
   logic [31:0] mon_rdata0 = 32'h0;
   logic [31:0] mon_rdata1 = 32'h0;
   logic [31:0] env_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] z_store = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] info);
      n_checks++;
      n_errors++;
      $display("FAIL %s: value 0x%08h", name, info);
   endtask

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] env_read(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : pat(a);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : pat(a);
   endfunction

   // Slow memory: data is correct only in the WS-th cycle after the strobe, garbage otherwise.
   initial begin
      int          ph;
      logic [31:0] ra;
      ph = 99;
      ra = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            ph = 0;
            ra = mem_addr;
         end else if (ph < 99) begin
            ph++;
         end
         mem_rdata = (ph == WS) ? env_read(ra) : ~env_read(ra);
         if (z_mem_en && z_mem_we) z_store = z_mem_wdata;
         z_mem_rdata = (z_mem_en && !z_mem_we) ? z_store : 32'hBAD0_BAD0;
      end
   end

   initial begin
      iss_t e;
      logic prev_en, prev_cr, prev_dr;
      prev_en = 1'b0; prev_cr = 1'b0; prev_dr = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            chk("mem_en_one_cycle", 32'(prev_en), 32'h0);
            chk("no_ready_during_access", 32'({cpu_ready, dbg_ready}), 32'h0);
            if (own_q.size() > 0) chk("grant_owner", 32'(owner), 32'(own_q.pop_front()));
            if ((owner ? iss_q1.size() : iss_q0.size()) == 0) begin
               flag("unexpected_access_addr", mem_addr);
            end else begin
               e = owner ? iss_q1.pop_front() : iss_q0.pop_front();
               chk("mem_we", 32'(mem_we), 32'(e.we));
               chk("mem_addr", mem_addr, e.addr);
               if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            end
         end
         if (cpu_ready) begin
            chk("cpu_ready_pulse", 32'(prev_cr), 32'h0);
            chk("single_ready", 32'(dbg_ready), 32'h0);
            if (cmp_q0.size() == 0) flag("unexpected_cpu_ready", cpu_rdata);
            else mon_rdata0 = cmp_q0.pop_front();
         end
         if (dbg_ready) begin
            chk("dbg_ready_pulse", 32'(prev_dr), 32'h0);
            if (cmp_q1.size() == 0) flag("unexpected_dbg_ready", dbg_rdata);
            else mon_rdata1 = cmp_q1.pop_front();
         end
         chk("cpu_rdata", cpu_rdata, mon_rdata0);
         chk("dbg_rdata", dbg_rdata, mon_rdata1);
         prev_en = mem_en; prev_cr = cpu_ready; prev_dr = dbg_ready;
      end
   end

   // exp_lat 0 means only the worst-case fairness bound applies.
   task automatic do_access(input bit who, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int exp_lat, input bit hold);
      iss_t e;
      int   n;
      logic seen;
      e.we = we; e.addr = addr; e.wdata = wdata;
      if (we) ref_mem[addr] = wdata;
      else    held[who] = ref_read(addr);
      if (who) begin
         iss_q1.push_back(e); cmp_q1.push_back(held[1]);
         dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      end else begin
         iss_q0.push_back(e); cmp_q0.push_back(held[0]);
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         seen = who ? dbg_ready : cpu_ready;
      end
      if (!seen) flag(who ? "dbg_ready_timeout" : "cpu_ready_timeout", addr);
      else if (exp_lat > 0) chk(who ? "dbg_latency" : "cpu_latency", 32'(n), 32'(exp_lat));
      else chk("latency_within_bound", 32'(n <= BOUND), 32'h1);
      if (hold) begin
         @(posedge clk); #1;
      end else if (who) begin
         dbg_req = 1'b0; dbg_we = 1'($urandom); dbg_addr = $urandom; dbg_wdata = $urandom;
      end else begin
         cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      iss_t e;
      int   n, en_cnt;
      logic seen;
      reset = 1'b0;
      {cpu_req, dbg_req, cpu_we, dbg_we} = 4'b0;
      {cpu_addr, dbg_addr, cpu_wdata, dbg_wdata} = '0;
      {z_cpu_req, z_dbg_req, z_cpu_we, z_dbg_we} = 4'b0;
      {z_cpu_addr, z_dbg_addr, z_cpu_wdata, z_dbg_wdata} = '0;
      held[0] = 32'h0;
      held[1] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_ready", 32'({cpu_ready, dbg_ready}), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_state", 32'(dbg_arbstate), 32'h0);
      chk("rst_ws0_state", 32'(z_dbg_arbstate), 32'h0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Both requesters continuously active straight out of reset.
      own_q.push_back(1'b0); own_q.push_back(1'b1); own_q.push_back(1'b0); own_q.push_back(1'b1);
      fork
         begin
            do_access(1'b0, 1'b1, 32'h80, 32'h1111_0000, 0, 1'b1);
            do_access(1'b0, 1'b0, 32'h80, 32'h0, 0, 1'b0);
         end
         begin
            do_access(1'b1, 1'b0, 32'h1080, 32'h0, 0, 1'b1);
            do_access(1'b1, 1'b1, 32'h1084, 32'h2222_3333, 0, 1'b0);
         end
      join
      chk("contention_grants_done", 32'(own_q.size()), 32'h0);
      repeat (2) @(posedge clk);
      #1;

      env_mem[32'h40] = 32'hDEAD_BEEF;
      ref_mem[32'h40] = 32'hDEAD_BEEF;
      do_access(1'b0, 1'b0, 32'h40, 32'h0, 2 + WS, 1'b0);
      chk("cpu_rdata_deadbeef", cpu_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;

      do_access(1'b0, 1'b0, 32'h40, 32'h0, 2 + WS, 1'b1);
      do_access(1'b0, 1'b0, 32'h44, 32'h0, 2 + WS, 1'b0);
      @(posedge clk); #1;

      // DBG raises its request in the CPU's first WAIT cycle.
      own_q.push_back(1'b0); own_q.push_back(1'b1);
      fork
         do_access(1'b0, 1'b0, 32'h48, 32'h0, 2 + WS, 1'b0);
         begin
            @(posedge clk); @(posedge clk); #1;
            do_access(1'b1, 1'b1, 32'h1010, 32'h0000_ABCD, 3 + 2 * WS, 1'b0);
         end
      join
      @(posedge clk); #1;

      e.we = 1'b0; e.addr = 32'h4C; e.wdata = 32'h0;
      iss_q0.push_back(e);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4C;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      cpu_req = 1'b0;
      held[0] = 32'h0; held[1] = 32'h0;
      mon_rdata0 = 32'h0; mon_rdata1 = 32'h0;
      #1;
      chk("rstwait_state", 32'(dbg_arbstate), 32'h0);
      chk("rstwait_mem_en", 32'(mem_en), 32'h0);
      chk("rstwait_mem_addr", mem_addr, 32'h0);
      chk("rstwait_owner", 32'(owner), 32'h0);
      chk("rstwait_rdata", cpu_rdata | dbg_rdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("no_ready_after_reset", 32'({cpu_ready, dbg_ready}), 32'h0);
      end
      do_access(1'b0, 1'b0, 32'h4C, 32'h0, 2 + WS, 1'b0);
      @(posedge clk); #1;

      fork
         begin
            for (int i = 0; i < 25; i++) begin
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
               do_access(1'b0, 1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7) * 4),
                         $urandom, 0, 1'b0);
            end
         end
         begin
            for (int j = 0; j < 25; j++) begin
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
               do_access(1'b1, 1'($urandom_range(0, 1)), 32'h1100 + 32'($urandom_range(0, 7) * 4),
                         $urandom, 0, 1'b0);
            end
         end
      join
      repeat (3) @(posedge clk);
      #1;
      chk("iss_q_drained", 32'(iss_q0.size() + iss_q1.size()), 32'h0);
      chk("cmp_q_drained", 32'(cmp_q0.size() + cmp_q1.size()), 32'h0);

      // Zero-wait-state instance: debug write then read-back of the same word.
      z_dbg_req = 1'b1; z_dbg_we = 1'b1; z_dbg_addr = 32'h10; z_dbg_wdata = 32'h1234;
      n = 0; en_cnt = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (z_mem_en) begin
            en_cnt++;
            chk("ws0_mem_we", 32'(z_mem_we), 32'h1);
            chk("ws0_mem_addr", z_mem_addr, 32'h10);
            chk("ws0_mem_wdata", z_mem_wdata, 32'h1234);
         end
         seen = z_dbg_ready;
      end
      chk("ws0_write_latency", 32'(n), 32'h2);
      chk("ws0_write_strobes", 32'(en_cnt), 32'h1);
      chk("ws0_rdata_after_write", z_cpu_rdata | z_dbg_rdata, 32'h0);
      z_dbg_req = 1'b0;
      @(posedge clk); #1;
      z_dbg_req = 1'b1; z_dbg_we = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         seen = z_dbg_ready;
      end
      z_dbg_req = 1'b0;
      chk("ws0_read_latency", 32'(n), 32'h2);
      chk("ws0_dbg_rdata", z_dbg_rdata, 32'h1234);
      chk("ws0_cpu_rdata", z_cpu_rdata, 32'h0);
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
